// File: rtl/layer_sequencer.sv
// layer_sequencer: steps a neural-network layer through MAC, BIAS and HOLD.
// Each output neuron gets 2^logNrns multiply-accumulate cycles, then a bias
// cycle, then a HOLD cycle that waits for downstream acceptance. After the
// last neuron is accepted, done pulses for one cycle.
// The next-state logic also computes the next value of every output, so each
// output comes straight from a flop.
module layer_sequencer #(
    parameter int logNrns = 5,   // input-neuron index bits; 2^logNrns inputs per neuron
    parameter int logOuts = 3,   // output-neuron index bits
    parameter int NOUT    = 8    // output neurons per layer, 1..2^logOuts
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       res_ready,
    output logic                       busy,
    output logic                       done,
    output logic [logNrns-1:0]         in_sel,
    output logic [logOuts-1:0]         out_sel,
    output logic [logNrns+logOuts-1:0] w_addr,
    output logic                       acc_clr,
    output logic                       mac_en,
    output logic                       bias_en,
    output logic                       res_valid
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAC  = 3'd1,
        BIAS = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [logNrns-1:0] LAST_IN  = '1;
    localparam logic [logOuts-1:0] LAST_OUT = logOuts'(NOUT - 1);

    state_t               state, state_d;
    logic [logNrns-1:0]   in_sel_d;
    logic [logOuts-1:0]   out_sel_d;
    logic                 busy_d, done_d, acc_clr_d, mac_en_d, bias_en_d, res_valid_d;

    // Next state, next selects, and the registered outputs that go with them.
    always_comb begin
        // NOTE: every signal gets a default value first. A path through the
        // case that skips a signal would otherwise infer a latch.
        state_d   = state;
        in_sel_d  = in_sel;
        out_sel_d = out_sel;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d   = MAC;
                    in_sel_d  = '0;
                    out_sel_d = '0;
                end
            end
            MAC: begin
                if (in_sel == LAST_IN) begin
                    // The column counter wraps to zero here and never runs past it.
                    state_d  = BIAS;
                    in_sel_d = '0;
                end else begin
                    in_sel_d = in_sel + 1'b1;
                end
            end
            BIAS: begin
                state_d = HOLD;
            end
            HOLD: begin
                // Hold the result and freeze both selects until the handshake completes.
                if (res_ready) begin
                    if (out_sel == LAST_OUT) begin
                        state_d = DONE;
                    end else begin
                        state_d   = MAC;
                        out_sel_d = out_sel + 1'b1;
                        in_sel_d  = '0;
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                in_sel_d  = '0;
                out_sel_d = '0;
            end
            default: begin
                state_d   = IDLE;
                in_sel_d  = '0;
                out_sel_d = '0;
            end
        endcase

        // abort overrides everything, including a start in IDLE.
        if (abort) begin
            state_d   = IDLE;
            in_sel_d  = '0;
            out_sel_d = '0;
        end

        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        mac_en_d    = (state_d == MAC);
        acc_clr_d   = (state_d == MAC) && (in_sel_d == '0);
        bias_en_d   = (state_d == BIAS);
        res_valid_d = (state_d == HOLD);
    end

    // State register and output flops; reset clears progress immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_sel    <= '0;
            out_sel   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            acc_clr   <= 1'b0;
            mac_en    <= 1'b0;
            bias_en   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments update all flops together at the
            // edge. Blocking assignments here would let later lines see the
            // new values.
            state     <= state_d;
            in_sel    <= in_sel_d;
            out_sel   <= out_sel_d;
            busy      <= busy_d;
            done      <= done_d;
            acc_clr   <= acc_clr_d;
            mac_en    <= mac_en_d;
            bias_en   <= bias_en_d;
            res_valid <= res_valid_d;
        end
    end

    // The weight address is two flop outputs placed side by side.
    assign w_addr = {out_sel, in_sel};

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer.
// One instance uses the default parameters. A second instance uses NOUT=1 and
// logNrns=2 to cover the single-neuron layer.
module tb_layer_sequencer;

    logic clk;
    logic rst_n;
    logic start, abort, res_ready;
    logic busy, done, acc_clr, mac_en, bias_en, res_valid;
    logic [4:0] in_sel;
    logic [2:0] out_sel;
    logic [7:0] w_addr;

    logic s_start, s_abort, s_res_ready;
    logic s_busy, s_done, s_acc_clr, s_mac_en, s_bias_en, s_res_valid;
    logic [1:0] s_in_sel;
    logic [2:0] s_out_sel;
    logic [4:0] s_w_addr;

    int unsigned n_vec;
    int unsigned n_miss;
    int unsigned done_cnt;
    int unsigned s_done_cnt;
    int unsigned saved_done;

    layer_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .res_ready(res_ready),
        .busy(busy), .done(done), .in_sel(in_sel), .out_sel(out_sel), .w_addr(w_addr),
        .acc_clr(acc_clr), .mac_en(mac_en), .bias_en(bias_en), .res_valid(res_valid)
    );

    layer_sequencer #(.logNrns(2), .logOuts(3), .NOUT(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .res_ready(s_res_ready),
        .busy(s_busy), .done(s_done), .in_sel(s_in_sel), .out_sel(s_out_sel), .w_addr(s_w_addr),
        .acc_clr(s_acc_clr), .mac_en(s_mac_en), .bias_en(s_bias_en), .res_valid(s_res_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses of both instances.
    always @(posedge clk) begin
        if (done === 1'b1)   done_cnt   <= done_cnt + 1;
        if (s_done === 1'b1) s_done_cnt <= s_done_cnt + 1;
    end

    // Flag order: {busy, done, acc_clr, mac_en, bias_en, res_valid}
    function automatic logic [5:0] flags();
        return {busy, done, acc_clr, mac_en, bias_en, res_valid};
    endfunction

    function automatic logic [5:0] s_flags();
        return {s_busy, s_done, s_acc_clr, s_mac_en, s_bias_en, s_res_valid};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one full layer of the default instance, starting at the first MAC
    // cycle. Neuron stall_n holds off res_ready for stall_len HOLD cycles.
    // poke adds ignored start pulses during MAC and during HOLD.
    task automatic run_layer(input int stall_n, input int stall_len, input bit poke);
        int stall;
        int rv;
        for (int n = 0; n < 8; n++) begin
            for (int p = 0; p < 32; p++) begin
                start = poke && (n == 0) && (p == 5);
                check("mac_flags", flags(), {1'b1, 1'b0, (p == 0), 1'b1, 1'b0, 1'b0});
                check("mac_addr", w_addr, n * 32 + p);
                tick();
            end
            start = 1'b0;
            check("bias_flags", flags(), 6'b100010);
            check("bias_addr", w_addr, n * 32);
            tick();
            stall = (n == stall_n) ? stall_len : 0;
            rv = 0;
            for (int j = 0; j <= stall; j++) begin
                res_ready = (j == stall);
                start     = poke && (n == 1) && (j == 0);
                check("hold_flags", flags(), 6'b100001);
                check("hold_out_sel", out_sel, n);
                check("hold_in_sel", in_sel, 0);
                rv++;
                tick();
            end
            res_ready = 1'b1;
            start     = 1'b0;
            if (n == stall_n) check("hold_len", rv, stall_len + 1);
        end
        check("done_flags", flags(), 6'b110000);
        tick();
        check("idle_flags", flags(), 6'b000000);
        check("idle_addr", w_addr, 0);
    endtask

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        done_cnt   = 0;
        s_done_cnt = 0;
        start = 1'b0; abort = 1'b0; res_ready = 1'b1;
        s_start = 1'b0; s_abort = 1'b0; s_res_ready = 1'b1;
        rst_n = 1'b1;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_flags", flags(), 6'b000000);
        check("rst_addr", w_addr, 0);
        check("rst_sel", {out_sel, in_sel}, 0);
        check("rst_s_flags", s_flags(), 6'b000000);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_after_rst", flags(), 6'b000000);

        // Full layer with res_ready held high: done on busy cycle 273.
        start = 1'b1;
        tick();
        start = 1'b0;
        run_layer(-1, 0, 1'b0);
        check("done_cnt_l1", done_cnt, 1);

        // Stall in neuron 3 HOLD; start pulses while busy are ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        run_layer(3, 5, 1'b1);
        check("done_cnt_l2", done_cnt, 2);
        for (int i = 0; i < 5; i++) begin
            check("no_queued_start", busy, 0);
            tick();
        end

        // Abort at in_sel=17, out_sel=2: busy cycle 2*34+17+1 = 86.
        saved_done = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (85) tick();
        check("pre_abort_in", in_sel, 17);
        check("pre_abort_out", out_sel, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_flags", flags(), 6'b000000);
        check("abort_addr", w_addr, 0);
        repeat (3) tick();
        check("abort_no_done", done_cnt, saved_done);
        check("abort_stays_idle", busy, 0);

        // abort and start together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_wins", flags(), 6'b000000);
        tick();
        check("abort_wins_hold", busy, 0);

        // A fresh start restarts at w_addr 0.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_flags", flags(), 6'b101100);
        check("restart_addr", w_addr, 0);
        repeat (9) tick();
        check("pre_rst_in", in_sel, 9);
        check("pre_rst_addr", w_addr, 9);

        // Reset asserted mid-cycle clears the outputs before the next edge.
        #2 rst_n = 1'b0;
        #1;
        check("midrst_flags", flags(), 6'b000000);
        check("midrst_addr", w_addr, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", flags(), 6'b000000);
        tick();
        check("post_rst_idle2", busy, 0);

        // Single-neuron layer with logNrns=2.
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int p = 0; p < 4; p++) begin
            check("s_mac_flags", s_flags(), {1'b1, 1'b0, (p == 0), 1'b1, 1'b0, 1'b0});
            check("s_mac_addr", s_w_addr, p);
            tick();
        end
        check("s_bias_flags", s_flags(), 6'b100010);
        tick();
        check("s_hold_flags", s_flags(), 6'b100001);
        check("s_hold_addr", s_w_addr, 0);
        tick();
        check("s_done_flags", s_flags(), 6'b110000);
        tick();
        check("s_idle_flags", s_flags(), 6'b000000);
        check("s_done_cnt", s_done_cnt, 1);
        check("final_done_cnt", done_cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
